instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction byte source for the 8080-subset core. Fetches opcode and immediate bytes from a synchronous program ROM through a small prefetch FIFO.
- Presents the byte at the FIFO head on the datapath input bus. The decoder consumes it with rIR_enable (opcode) or data_in_select (MVI immediate).
- Owns the 2-bit instruction step counter that the decoder reads, and stalls that counter while no byte is available.

Parameters:
- ADDR_W, 8, program counter / ROM address width.
- DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2.
- START_ADDR, 0, PC value after reset.
- HLT_OPCODE, 8'h76, opcode that stops fetching.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- run  in  1  1 = issue ROM reads; 0 = pause issuing.
- mem_addr  out  ADDR_W  ROM address, equal to PC.
- mem_rd  out  1  ROM read strobe.
- mem_rdata  in  8  ROM data, valid exactly 1 cycle after a mem_rd cycle.
- data_out  out  8  FIFO head byte; 0 when empty.
- data_valid  out  1  FIFO not empty.
- consume  in  1  pop the head byte (rIR_enable OR data_in_select).
- counter_clear  in  1  from decoder; resets the step counter.
- counter  out  2  instruction step counter.
- halted  out  1  HLT_OPCODE has been consumed.

Behaviour:
- Reset (async, immediate): PC=START_ADDR, FIFO empty, inflight=0, counter=0, halted=0.
  - Outputs during reset: mem_rd=0, data_valid=0, data_out=0.
- Read issue:
  - mem_rd=1 in a cycle iff run=1, halted=0, and (count + inflight) < DEPTH.
  - On an issue edge: PC <= PC+1, wrapping modulo 2^ADDR_W; inflight <= 1.
  - mem_rd is combinational from registered state, so back-to-back issues are allowed. In steady state one byte is read per cycle.
- Return: in the cycle after an issue, mem_rdata is pushed at the tail and inflight clears. Space is guaranteed by the issue rule, so no overflow is possible.
- Pop:
  - consume=1 with data_valid=1 advances the head pointer.
  - consume=1 while empty is ignored: no pointer change, no error.
  - Push and pop in the same cycle leave count unchanged.
  - If the FIFO is empty, a returning byte is visible on data_out one cycle after the return edge. There is no bypass.
- Occupancy: count ranges 0..DEPTH. Pointers are log2(DEPTH) bits and wrap naturally.
- Halt:
  - Popping a byte equal to HLT_OPCODE sets halted=1 at that edge. Only reset clears it.
  - While halted: no new issues. An in-flight return is still pushed. Remaining bytes can still be popped.
  - An immediate byte equal to 8'h76 also sets halted. Callers do not place 8'h76 as an MVI operand.
- Step counter, in priority order each edge:
  - counter_clear=1 -> counter=0.
  - else data_valid=0 -> hold.
  - else counter+1, 2-bit wrap (3 -> 0).
- Simultaneous events:
  - counter_clear together with consume: both take effect.
  - run falling with a read in flight: that return is still pushed.
- Reset asserted mid-read: the pending return is discarded because inflight clears and no push occurs.

Test Plan:
- Reset then run=1, consume=0, ROM[0..7]=8'h10..8'h17:
  - mem_rd pulses at addresses 0,1,2,3, then stops.
  - count=4, data_out=8'h10, data_valid=1.
- Continuous consume=1 on the same ROM:
  - data_out sequence 10,11,12,...; one byte per cycle after the initial fill.
  - No duplicates and no skips.
- Program 3E 5A 80 76 (MVI A,5A; ADD B; HLT), driven by a decoder model:
  - counter runs 0,1 for MVI and 0,1,2 for ADD.
  - counter_clear returns counter to 0.
  - halted=1 after the 76 pop; mem_rd stays 0 afterward.
- Empty stall: ROM responses delayed by holding run=0:
  - counter holds at its value while data_valid=0.
  - consume=1 while empty leaves state unchanged.
- ADDR_W=3, run from reset with continuous consume:
  - mem_addr goes 6,7,0,1; data wraps correctly.
- Assert reset in the cycle after a mem_rd:
  - Next cycle: data_valid=0, counter=0, PC=START_ADDR.
  - The returning byte never appears.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction byte source: issues reads to a synchronous program ROM, buffers the returned bytes
// in a small prefetch FIFO, and owns the decoder's 2-bit step counter.
module instr_fetch #(
  parameter int               ADDR_W     = 8,
  parameter int               DEPTH      = 4,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [7:0]       HLT_OPCODE = 8'h76
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        data_out,
  output logic              data_valid,
  input  logic              consume,
  input  logic              counter_clear,
  output logic [1:0]        counter,
  output logic              halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_LIM = DEPTH[CW:0];

  logic [ADDR_W-1:0] pc;
  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic [CW-1:0]     count;
  logic              inflight;
  logic [7:0]        fifoMem [DEPTH];
  logic [CW:0]       occupancy;
  logic              doPush;
  logic              doPop;

  // A slot is reserved for every read in flight, so a return can never overflow the FIFO.
  assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign mem_rd     = !reset && run && !halted && (occupancy < DEPTH_LIM);
  assign mem_addr   = pc;
  assign doPush     = inflight;
  assign doPop      = consume && data_valid;
  assign data_valid = (count != '0);
  assign data_out   = data_valid ? fifoMem[rdPtr] : 8'h00;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= START_ADDR;
      inflight <= 1'b0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
    end else begin
      if (mem_rd) pc <= pc + ADDR_W'(1);
      inflight <= mem_rd;
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count gates every read of it, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (doPush) fifoMem[wrPtr] <= mem_rdata;
  end

  // Step counter advances only while a byte is available for the decoder.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= 2'd0;
      halted  <= 1'b0;
    end else begin
      if (doPop && (data_out == HLT_OPCODE)) halted <= 1'b1;
      if (counter_clear)   counter <= 2'd0;
      else if (data_valid) counter <= counter + 2'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a queue-based reference model of the fetch path is
// compared against the DUT every cycle under directed and randomized stimulus.
module tb_instr_fetch;

  localparam int         DEPTH = 4;
  localparam logic [7:0] HLT   = 8'h76;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, run, consume, counter_clear;
  logic [7:0] mem_addr, mem_rdata, data_out;
  logic       mem_rd, data_valid, halted;
  logic [1:0] counter;

  logic       run2, consume2, clear2;
  logic [2:0] mem_addr2;
  logic [7:0] mem_rdata2, data_out2;
  logic       mem_rd2, data_valid2, halted2;
  logic [1:0] counter2;

  instr_fetch #(.ADDR_W(8), .DEPTH(DEPTH), .START_ADDR(8'h00), .HLT_OPCODE(HLT)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .data_out(data_out), .data_valid(data_valid),
    .consume(consume), .counter_clear(counter_clear), .counter(counter), .halted(halted)
  );

  instr_fetch #(.ADDR_W(3), .DEPTH(DEPTH), .START_ADDR(3'd6), .HLT_OPCODE(HLT)) dut2 (
    .clk(clk), .reset(reset), .run(run2), .mem_addr(mem_addr2), .mem_rd(mem_rd2),
    .mem_rdata(mem_rdata2), .data_out(data_out2), .data_valid(data_valid2),
    .consume(consume2), .counter_clear(clear2), .counter(counter2), .halted(halted2)
  );

  logic [7:0] rom  [256];
  logic [7:0] rom2 [8];

  // Synchronous ROMs: data one cycle after a read strobe, junk otherwise.
  always @(posedge clk) mem_rdata  <= mem_rd  ? rom[mem_addr]   : 8'hEE;
  always @(posedge clk) mem_rdata2 <= mem_rd2 ? rom2[mem_addr2] : 8'hEE;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: the FIFO as a queue of bytes plus one outstanding ROM request.
  logic [7:0] qM [$];
  logic [7:0] pcM, inflAddr;
  bit         inflM, hM;
  logic [1:0] cntM;

  task automatic model_reset();
    qM.delete();
    pcM = 8'h00; inflAddr = 8'h00; inflM = 0; hM = 0; cntM = 2'd0;
  endtask

  task automatic model_edge(input bit r, input bit c, input bit clr);
    bit         iss, hadData;
    logic [7:0] head;
    hadData = (qM.size() > 0);
    iss = r && !hM && ((qM.size() + int'(inflM)) < DEPTH);
    if (c && hadData) begin
      head = qM.pop_front();
      if (head == HLT) hM = 1;
    end
    if (inflM) begin
      qM.push_back(rom[inflAddr]);
      inflM = 0;
    end
    if (clr) cntM = 2'd0;
    else if (hadData) cntM = cntM + 2'd1;
    if (iss) begin
      inflM = 1; inflAddr = pcM; pcM = pcM + 8'd1;
    end
  endtask

  // One clock of the main DUT: drive, compare against the model, advance both.
  task automatic step(input bit r, input bit c, input bit clr);
    bit         expRd, expValid;
    logic [7:0] expOut;
    run = r; consume = c; counter_clear = clr;
    #1;
    expRd    = r && !hM && ((qM.size() + int'(inflM)) < DEPTH);
    expValid = (qM.size() > 0);
    expOut   = expValid ? qM[0] : 8'h00;
    checks++; if (mem_rd !== expRd) begin errors++; $display("FAIL mem_rd cyc=%0d got=%b exp=%b", cyc, mem_rd, expRd); end
    checks++; if (mem_addr !== pcM) begin errors++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, pcM); end
    checks++; if (data_valid !== expValid) begin errors++; $display("FAIL data_valid cyc=%0d got=%b exp=%b", cyc, data_valid, expValid); end
    checks++; if (data_out !== expOut) begin errors++; $display("FAIL data_out cyc=%0d got=%h exp=%h", cyc, data_out, expOut); end
    checks++; if (counter !== cntM) begin errors++; $display("FAIL counter cyc=%0d got=%0d exp=%0d", cyc, counter, cntM); end
    checks++; if (halted !== hM) begin errors++; $display("FAIL halted cyc=%0d got=%b exp=%b", cyc, halted, hM); end
    model_edge(r, c, clr);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b1; consume = 1'b1; counter_clear = 1'b0;
    run2 = 1'b1; consume2 = 1'b0; clear2 = 1'b0;
    #1;
    checks++; if (mem_rd !== 1'b0 || mem_rd2 !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got=%b/%b exp=0", mem_rd, mem_rd2); end
    checks++; if (data_valid !== 1'b0 || data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%b/%h exp=0/00", data_valid, data_out); end
    checks++; if (counter !== 2'd0 || halted !== 1'b0) begin errors++; $display("FAIL reset_ctr got=%0d/%b exp=0/0", counter, halted); end
    checks++; if (mem_addr !== 8'h00 || mem_addr2 !== 3'd6) begin errors++; $display("FAIL reset_pc got=%h/%0d exp=00/6", mem_addr, mem_addr2); end
    @(posedge clk); #1;
    reset = 1'b0; run2 = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 256; i++) rom[i] = (i < 8) ? 8'(8'h10 + i) : 8'(i ^ 8'h5A);
    rom[8'h76 ^ 8'h5A] = 8'h00;
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    #1;
    checks++; if (mem_addr !== 8'd4 || mem_rd !== 1'b0) begin errors++; $display("FAIL fill_stop got=%h/%b exp=04/0", mem_addr, mem_rd); end
    checks++; if (data_out !== 8'h10 || data_valid !== 1'b1) begin errors++; $display("FAIL fill_head got=%h/%b exp=10/1", data_out, data_valid); end
    @(posedge clk); #1;
    model_edge(1, 0, 0);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 24; i++) step(1, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'($urandom_range(0, 255));
      if (rom[i] == HLT) rom[i] = 8'h77;
    end
    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
  endtask

  task automatic test_program();
    logic [7:0] op, imm;
    logic [7:0] ops [$];
    logic [1:0] trace [$];
    logic [1:0] expTrace [7];
    logic [7:0] expOps [3];
    bit done, c, clr;
    expTrace = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    expOps   = '{8'h3E, 8'h80, 8'h76};
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h3E; rom[1] = 8'h5A; rom[2] = 8'h80; rom[3] = 8'h76;
    do_reset();
    op = 8'h00; imm = 8'h00; done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      c = 0; clr = 0;
      if (trace.size() == 0 || trace[trace.size()-1] != counter) trace.push_back(counter);
      case (counter)
        2'd0: if (data_valid) begin c = 1; op = data_out; ops.push_back(op); end
        2'd1: if (op == 8'h3E) begin
                if (data_valid) begin c = 1; clr = 1; imm = data_out; end
              end else if (op == 8'h76) begin
                clr = 1; done = 1;
              end
        2'd2: if (op == 8'h80) clr = 1;
        default: ;
      endcase
      step(1, c, clr);
    end
    checks++; if (!done) begin errors++; $display("FAIL prog_timeout got=not_done exp=done"); end
    checks++; if (imm !== 8'h5A) begin errors++; $display("FAIL prog_imm got=%h exp=5a", imm); end
    checks++; if (ops.size() != 3) begin errors++; $display("FAIL prog_nops got=%0d exp=3", ops.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (ops[i] !== expOps[i]) begin errors++; $display("FAIL prog_op%0d got=%h exp=%h", i, ops[i], expOps[i]); end
    end
    checks++; if (trace.size() != 7) begin errors++; $display("FAIL prog_trace_len got=%0d exp=7", trace.size()); end
    else for (int i = 0; i < 7; i++) begin
      checks++; if (trace[i] !== expTrace[i]) begin errors++; $display("FAIL prog_trace%0d got=%0d exp=%0d", i, trace[i], expTrace[i]); end
    end
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    #1;
    checks++; if (halted !== 1'b1 || mem_rd !== 1'b0) begin errors++; $display("FAIL prog_halt got=%b/%b exp=1/0", halted, mem_rd); end
    @(posedge clk); #1;
    model_edge(1, 0, 0);
  endtask

  task automatic test_empty_stall();
    do_reset();
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    #1;
    checks++; if (counter !== 2'd2) begin errors++; $display("FAIL stall_counter got=%0d exp=2", counter); end
    checks++; if (data_valid !== 1'b0 || data_out !== 8'h00) begin errors++; $display("FAIL stall_empty got=%b/%h exp=0/00", data_valid, data_out); end
    checks++; if (mem_addr !== 8'd1) begin errors++; $display("FAIL stall_pc got=%h exp=01", mem_addr); end
    @(posedge clk); #1;
    model_edge(0, 1, 0);
  endtask

  task automatic test_reset_midread();
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    reset = 1'b1;
    #1;
    checks++; if (counter !== 2'd0 || data_valid !== 1'b0) begin errors++; $display("FAIL midrd_clear got=%0d/%b exp=0/0", counter, data_valid); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL midrd_pc got=%h exp=00", mem_addr); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0);
  endtask

  task automatic test_addr_wrap();
    logic [2:0] addrs [$];
    logic [7:0] pops [$];
    for (int i = 0; i < 8; i++) rom2[i] = 8'(8'hA0 + i);
    do_reset();
    run = 1'b0; consume = 1'b0;
    run2 = 1'b1; consume2 = 1'b1;
    for (int n = 0; n < 16; n++) begin
      #1;
      if (mem_rd2) addrs.push_back(mem_addr2);
      if (data_valid2) pops.push_back(data_out2);
      @(posedge clk); #1;
    end
    run2 = 1'b0; consume2 = 1'b0;
    checks++; if (addrs.size() < 4 || pops.size() < 8) begin errors++; $display("FAIL wrap_len got=%0d/%0d exp=>=4/>=8", addrs.size(), pops.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (addrs[i] !== 3'((6 + i) % 8)) begin errors++; $display("FAIL wrap_addr%0d got=%0d exp=%0d", i, addrs[i], (6 + i) % 8); end
      end
      for (int i = 0; i < 8; i++) begin
        checks++; if (pops[i] !== rom2[(6 + i) % 8]) begin errors++; $display("FAIL wrap_data%0d got=%h exp=%h", i, pops[i], rom2[(6 + i) % 8]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom2[i] = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    test_reset();
    test_fill();
    test_stream();
    test_random();
    test_program();
    test_empty_stall();
    test_reset_midread();
    test_addr_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
